burst_cmd_pipe: RTL

- Parametrised successor to the single-queue burst pipeline in the memory controller.
- Accepts host requests (rw, physical address, write burst data) with a valid/ready handshake and maps the physical address to the DDR address through a configurable bit table.
- Holds pending CAS and read/write data entries in two bounded FIFOs and drives one registered command per cycle from the controller's *_rdy strobes.
- Serialises write bursts (preamble plus BL beats, 4 or 8) onto the DQ bus. Adds backpressure, overflow/underflow detection, strobe arbitration and BC4/BL8 selection.

---
 rtl/burst_cmd_pipe_pkg.sv | 48 ++++
 rtl/burst_cmd_pipe_fifo.sv | 63 ++++++
 rtl/burst_cmd_pipe.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_cmd_pipe_pkg.sv
// Shared command encodings, FIFO entry layouts and the default
// physical-to-DDR address bit map for the burst command pipeline.
package ddr_package;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    ACT   = 4'd1,
    CAS_R = 4'd2,
    CAS_W = 4'd3,
    MRS   = 4'd4,
    DES   = 4'd5,
    PRE   = 4'd6,
    REF   = 4'd7,
    ZQCL  = 4'd8
  } command_type;

  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam int unsigned DEF_TA_WIDTH = 29;
  localparam int unsigned DEF_DQ_WIDTH = 16;

  typedef struct packed {
    logic [DEF_TA_WIDTH-1:0] addr;
    logic [1:0]              rw;
  } cas_entry_t;

  typedef struct packed {
    logic [1:0]                rw;
    logic [8*DEF_DQ_WIDTH-1:0] wdata;
    logic                      bc4;
    logic [1:0]                wpre;
  } rw_entry_t;

  // Entry i selects the physical address bit that drives DDR address bit i.
  localparam int unsigned DEF_MAP_TABLE [DEF_TA_WIDTH] = '{
    3,  4,  5,  6,  7,  8,  9,  10, 11, 12,
    13, 14, 15, 16, 17, 18, 19, 20, 21, 22,
    23, 24, 25, 26, 27, 28, 29, 30, 31
  };

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_PRE,
    SER_BURST
  } ser_state_t;

endpackage

// File: rtl/burst_cmd_pipe_fifo.sv
// Synchronous show-ahead FIFO with full/empty/level; a pop on empty
// is ignored and a push on full is taken only alongside a real pop.
module burst_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (PW+1)'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/burst_cmd_pipe.sv
// Host request to DDR command pipeline: address mapping, CAS/RW queues,
// strobe arbitration and the write-burst serializer onto DQ.
module burst_cmd_pipe
  import ddr_package::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TA_WIDTH   = DEF_TA_WIDTH,
  parameter int unsigned DQ_WIDTH   = DEF_DQ_WIDTH,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MR_WIDTH   = 18,
  parameter int unsigned MAP_TABLE [TA_WIDTH] = DEF_MAP_TABLE
) (
  input  logic                    clock_t,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [8*DQ_WIDTH-1:0]   req_wdata,
  input  logic                    act_rdy,
  input  logic                    cas_rdy,
  input  logic                    rw_rdy,
  input  logic                    mrs_rdy,
  input  logic                    des_rdy,
  input  logic                    pre_rdy,
  input  logic                    ref_rdy,
  input  logic                    zqcl_rdy,
  input  logic [MR_WIDTH-1:0]     mode_reg,
  input  logic                    bl_sel,
  input  logic [1:0]              wpre,
  output logic [3:0]              cmd,
  output logic [TA_WIDTH-1:0]     cmd_addr,
  output logic [1:0]              cmd_rw,
  output logic [1:0]              dimm_rd,
  output logic [DQ_WIDTH-1:0]     dq_out,
  output logic                    dq_valid,
  output logic                    dqs_en,
  output logic [$clog2(DEPTH):0]  cas_level,
  output logic [$clog2(DEPTH):0]  rw_level,
  output logic                    err_ovf,
  output logic                    err_unf,
  output logic                    err_conflict
);

  localparam int unsigned AIW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
  localparam int unsigned MCW = MR_WIDTH + 10;

  typedef struct packed {
    logic [TA_WIDTH-1:0] addr;
    logic [1:0]          rw;
  } cas_t;

  typedef struct packed {
    logic [1:0]            rw;
    logic [8*DQ_WIDTH-1:0] wdata;
    logic                  bc4;
    logic [1:0]            wpre;
  } rwe_t;

  logic [TA_WIDTH-1:0] mapped;
  logic [TA_WIDTH-1:0] mr_addr;
  logic [MCW-1:0]      mr_cat;

  for (genvar i = 0; i < TA_WIDTH; i++) begin : g_map
    localparam logic [AIW-1:0] IDX = AIW'(MAP_TABLE[i]);
    assign mapped[i] = req_addr[IDX];
  end

  assign mr_cat  = {mode_reg, 10'h001};
  assign mr_addr = TA_WIDTH'(mr_cat);

  cas_t cas_wdata, cas_rdata;
  rwe_t rw_wdata, rw_rdata;
  logic cas_push, cas_pop, cas_full, cas_empty;
  logic rw_pop, rw_full, rw_empty;

  assign cas_wdata = {mapped, req_rw};
  assign rw_wdata  = {req_rw, req_wdata, bl_sel, wpre};
  assign req_ready = !cas_full && !rw_full;

  burst_fifo #(
    .WIDTH ($bits(cas_t)),
    .DEPTH (DEPTH)
  ) u_cas_fifo (
    .clk_i   (clock_t),
    .rst_i   (reset),
    .push_i  (cas_push),
    .pop_i   (cas_pop),
    .wdata_i (cas_wdata),
    .rdata_o (cas_rdata),
    .full_o  (cas_full),
    .empty_o (cas_empty),
    .level_o (cas_level)
  );

  burst_fifo #(
    .WIDTH ($bits(rwe_t)),
    .DEPTH (DEPTH)
  ) u_rw_fifo (
    .clk_i   (clock_t),
    .rst_i   (reset),
    .push_i  (cas_push),
    .pop_i   (rw_pop),
    .wdata_i (rw_wdata),
    .rdata_o (rw_rdata),
    .full_o  (rw_full),
    .empty_o (rw_empty),
    .level_o (rw_level)
  );

  logic [6:0] stb;
  logic       multi;

  assign stb   = {zqcl_rdy, ref_rdy, mrs_rdy, pre_rdy,
                  des_rdy, cas_rdy, act_rdy};
  assign multi = (stb & (stb - 7'd1)) != 7'd0;

  command_type         cmd_q, cmd_d;
  logic [TA_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [1:0]          cmd_rw_q, cmd_rw_d;
  logic                ovf_set, unf_cas;

  always_comb begin
    cmd_d      = NOP;
    cmd_addr_d = '1;
    cmd_rw_d   = cmd_rw_q;
    cas_push   = 1'b0;
    cas_pop    = 1'b0;
    ovf_set    = 1'b0;
    unf_cas    = 1'b0;
    priority case (1'b1)
      zqcl_rdy: begin
        cmd_d      = ZQCL;
        cmd_addr_d = mr_addr;
      end
      ref_rdy: cmd_d = REF;
      mrs_rdy: begin
        cmd_d      = MRS;
        cmd_addr_d = mr_addr;
      end
      pre_rdy: begin
        cmd_d      = PRE;
        cmd_addr_d = mr_addr;
      end
      des_rdy: begin
        cmd_d      = DES;
        cmd_addr_d = mr_addr;
      end
      cas_rdy: begin
        if (cas_empty) begin
          unf_cas = 1'b1;
        end else begin
          cas_pop    = 1'b1;
          cmd_addr_d = cas_rdata.addr;
          cmd_rw_d   = cas_rdata.rw;
          if (cas_rdata.rw == RW_READ)       cmd_d = CAS_R;
          else if (cas_rdata.rw == RW_WRITE) cmd_d = CAS_W;
          else                               cmd_d = NOP;
        end
      end
      act_rdy: begin
        if (req_valid && req_ready) begin
          cas_push   = 1'b1;
          cmd_d      = ACT;
          cmd_addr_d = mapped;
        end else if (!req_ready) begin
          ovf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Write serializer: preamble count, then BL beats from the popped entry.
  ser_state_t            state_q, state_d;
  logic [1:0]            pre_q, pre_d;
  logic [2:0]            beat_q, beat_d;
  logic                  bc4_q, bc4_d;
  logic [8*DQ_WIDTH-1:0] data_q, data_d;
  logic [1:0]            dimm_q, dimm_d;
  logic                  unf_rw, conf_rw;
  logic [2:0]            last_beat;

  assign last_beat = bc4_q ? 3'd3 : 3'd7;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    beat_d  = beat_q;
    bc4_d   = bc4_q;
    data_d  = data_q;
    dimm_d  = dimm_q;
    rw_pop  = 1'b0;
    unf_rw  = 1'b0;
    conf_rw = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        if (rw_rdy) begin
          if (rw_empty) begin
            unf_rw = 1'b1;
          end else begin
            rw_pop = 1'b1;
            dimm_d = rw_rdata.rw;
            if (rw_rdata.rw == RW_WRITE) begin
              state_d = SER_PRE;
              pre_d   = rw_rdata.wpre;
              bc4_d   = rw_rdata.bc4;
              data_d  = rw_rdata.wdata;
              beat_d  = '0;
            end
          end
        end
      end
      SER_PRE: begin
        conf_rw = rw_rdy;
        if (pre_q <= 2'd1) state_d = SER_BURST;
        else               pre_d   = pre_q - 2'd1;
      end
      SER_BURST: begin
        conf_rw = rw_rdy;
        if (beat_q == last_beat) state_d = SER_IDLE;
        else                     beat_d  = beat_q + 3'd1;
      end
      default: state_d = SER_IDLE;
    endcase
  end

  logic [DQ_WIDTH-1:0] beat_slices [8];

  for (genvar k = 0; k < 8; k++) begin : g_beat
    assign beat_slices[k] = data_q[k*DQ_WIDTH +: DQ_WIDTH];
  end

  assign dqs_en   = (state_q != SER_IDLE);
  assign dq_valid = (state_q == SER_BURST);
  assign dq_out   = dq_valid ? beat_slices[beat_q] : '0;

  logic ovf_q, unf_q, conf_q;

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      cmd_q      <= NOP;
      cmd_addr_q <= '1;
      cmd_rw_q   <= '0;
      dimm_q     <= '0;
      state_q    <= SER_IDLE;
      pre_q      <= '0;
      beat_q     <= '0;
      bc4_q      <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      conf_q     <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_rw_q   <= cmd_rw_d;
      dimm_q     <= dimm_d;
      state_q    <= state_d;
      pre_q      <= pre_d;
      beat_q     <= beat_d;
      bc4_q      <= bc4_d;
      data_q     <= data_d;
      ovf_q      <= ovf_q | ovf_set;
      unf_q      <= unf_q | unf_cas | unf_rw;
      conf_q     <= conf_q | multi | conf_rw;
    end
  end

  assign cmd          = cmd_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_rw       = cmd_rw_q;
  assign dimm_rd      = dimm_q;
  assign err_ovf      = ovf_q;
  assign err_unf      = unf_q;
  assign err_conflict = conf_q;

endmodule
